pipe_skid_slice: RTL and testbench

- Full-throughput valid/ready register slice built as a 2-entry skid buffer.
- Cuts every combinational path between upstream and downstream: s_ready_o, m_valid_o and m_data_o all come straight from flops.
- Sits between any producer/consumer pair of our bus and stream blocks; it completes the handshake on both sides (receiver upstream, transmitter downstream).

---
 rtl/pipe_skid_slice.sv | 104 ++++++++++
 tb/tb_pipe_skid_slice.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_slice.sv
// Two-entry skid-buffer register slice for valid/ready streams.
// Every output (s_ready_o, m_valid_o, m_data_o, count_o) comes from a flop.
module pipe_skid_slice #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_r;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic                  m_valid_r;
    logic                  s_ready_r;
    logic [1:0]            count_r;
    logic                  s_hs_s;
    logic                  m_hs_s;

    // Output decode for a state, packed as {m_valid, s_ready, count}.
    function automatic logic [3:0] outs_f(input state_e st);
        logic [3:0] o;
        case (st)
            EMPTY:   o = {1'b0, 1'b1, 2'd0};
            ONE:     o = {1'b1, 1'b1, 2'd1};
            FULL:    o = {1'b1, 1'b0, 2'd2};
            default: o = {1'b0, 1'b1, 2'd0};
        endcase
        return o;
    endfunction

    // Handshakes are formed only from registered outputs and raw inputs.
    always_comb begin
        s_hs_s = s_valid_i & s_ready_r;
        m_hs_s = m_valid_r & m_ready_i;
    end

    // Slice FSM with storage; output flags are loaded alongside the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r                           <= EMPTY;
            {m_valid_r, s_ready_r, count_r}   <= outs_f(EMPTY);
            main_r                            <= '0;
            skid_r                            <= '0;
        end else if (flush_i) begin
            // Storage keeps its contents; only occupancy is cleared.
            state_r                           <= EMPTY;
            {m_valid_r, s_ready_r, count_r}   <= outs_f(EMPTY);
        end else begin
            case (state_r)
                EMPTY: begin
                    if (s_hs_s) begin
                        main_r                          <= s_data_i;
                        state_r                         <= ONE;
                        {m_valid_r, s_ready_r, count_r} <= outs_f(ONE);
                    end
                end
                ONE: begin
                    if (s_hs_s && m_hs_s) begin
                        main_r                          <= s_data_i;
                    end else if (s_hs_s) begin
                        skid_r                          <= s_data_i;
                        state_r                         <= FULL;
                        {m_valid_r, s_ready_r, count_r} <= outs_f(FULL);
                    end else if (m_hs_s) begin
                        state_r                         <= EMPTY;
                        {m_valid_r, s_ready_r, count_r} <= outs_f(EMPTY);
                    end
                end
                FULL: begin
                    // s_ready_o is low here, so only the drain side can move.
                    if (m_hs_s) begin
                        main_r                          <= skid_r;
                        state_r                         <= ONE;
                        {m_valid_r, s_ready_r, count_r} <= outs_f(ONE);
                    end
                end
                default: begin
                    state_r                             <= EMPTY;
                    {m_valid_r, s_ready_r, count_r}     <= outs_f(EMPTY);
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_r;
    assign m_valid_o = m_valid_r;
    assign m_data_o  = main_r;
    assign count_o   = count_r;

endmodule

// File: tb/tb_pipe_skid_slice.sv
// Directed and scoreboarded bench for pipe_skid_slice.
module tb_pipe_skid_slice;

    localparam int unsigned DW = 32;
    localparam int unsigned N_RAND = 1000;

    logic          clk_s;
    logic          rst_n_s;
    logic          flush_s;
    logic          s_valid_s;
    logic          s_ready_s;
    logic [DW-1:0] s_data_s;
    logic          m_valid_s;
    logic          m_ready_s;
    logic [DW-1:0] m_data_s;
    logic [1:0]    count_s;

    int total_r;
    int bad_r;

    pipe_skid_slice #(.DATA_WIDTH(DW)) dut (
        .clk_i     (clk_s),
        .rst_n_i   (rst_n_s),
        .flush_i   (flush_s),
        .s_valid_i (s_valid_s),
        .s_ready_o (s_ready_s),
        .s_data_i  (s_data_s),
        .m_valid_o (m_valid_s),
        .m_ready_i (m_ready_s),
        .m_data_o  (m_data_s),
        .count_o   (count_s)
    );

    // Free-running clock.
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

`ifndef SV_ASSRT_DISABLE
    // Held output stays valid and stable until it is taken.
    a_hold: assert property (@(posedge clk_s) disable iff (!rst_n_s)
        (m_valid_s && !m_ready_s && !flush_s) |=> (m_valid_s && $stable(m_data_s)));
    a_count: assert property (@(posedge clk_s) disable iff (!rst_n_s) count_s != 2'd3);
    a_x_sv: assert property (@(posedge clk_s) disable iff (!rst_n_s) !$isunknown(s_valid_s));
    a_x_mr: assert property (@(posedge clk_s) disable iff (!rst_n_s) !$isunknown(m_ready_s));
    a_x_fl: assert property (@(posedge clk_s) disable iff (!rst_n_s) !$isunknown(flush_s));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_r = total_r + 1;
        if (obs !== exp) begin
            bad_r = bad_r + 1;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic r, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(m_valid_s), 32'(v));
        chk({tag, ".ready"}, 32'(s_ready_s), 32'(r));
        chk({tag, ".count"}, 32'(count_s), 32'(c));
    endtask

    logic [DW-1:0] q_s[$];
    int            sent_r;
    int            recv_r;
    int            cyc_r;
    logic          sv_s;
    logic          mr_s;
    logic          exp_v_s;
    logic          exp_r_s;

    initial begin
        total_r   = 0;
        bad_r     = 0;
        rst_n_s   = 1'b0;
        flush_s   = 1'b0;
        s_valid_s = 1'b0;
        s_data_s  = 32'h0;
        m_ready_s = 1'b0;
        repeat (2) tick();

        // Reset state, then one idle edge after release.
        chk_state("rst", 1'b0, 1'b1, 2'd0);
        chk("rst.data", m_data_s, 32'h0);
        rst_n_s = 1'b1;
        tick();
        chk_state("rel", 1'b0, 1'b1, 2'd0);
        chk("rel.data", m_data_s, 32'h0);

        // Full-rate stream: each word visible right after its accept edge.
        m_ready_s = 1'b1;
        s_valid_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data_s = 32'(i);
            tick();
            chk_state($sformatf("str%0d", i), 1'b1, 1'b1, 2'd1);
            chk($sformatf("str%0d.data", i), m_data_s, 32'(i));
        end
        s_valid_s = 1'b0;
        tick();
        chk_state("str_end", 1'b0, 1'b1, 2'd0);

        // Backpressure fills the skid entry.
        m_ready_s = 1'b0;
        s_valid_s = 1'b1;
        s_data_s  = 32'hA1;
        tick();
        chk_state("bp1", 1'b1, 1'b1, 2'd1);
        s_data_s  = 32'hB2;
        tick();
        chk_state("bp2", 1'b1, 1'b0, 2'd2);
        chk("bp2.data", m_data_s, 32'hA1);
        s_valid_s = 1'b0;
        tick();
        chk_state("bp_hold", 1'b1, 1'b0, 2'd2);
        chk("bp_hold.data", m_data_s, 32'hA1);
        m_ready_s = 1'b1;
        tick();
        chk_state("drain1", 1'b1, 1'b1, 2'd1);
        chk("drain1.data", m_data_s, 32'hB2);
        tick();
        chk_state("drain2", 1'b0, 1'b1, 2'd0);
        chk("drain2.stale", m_data_s, 32'hB2);

        // Flush while FULL: head delivered in the flush cycle, skid dropped.
        m_ready_s = 1'b0;
        s_valid_s = 1'b1;
        s_data_s  = 32'h11;
        tick();
        s_data_s  = 32'h22;
        tick();
        chk_state("fl_full", 1'b1, 1'b0, 2'd2);
        s_valid_s = 1'b0;
        m_ready_s = 1'b1;
        flush_s   = 1'b1;
        chk("fl_head", m_data_s, 32'h11);
        tick();
        flush_s   = 1'b0;
        chk_state("fl_after", 1'b0, 1'b1, 2'd0);
        chk("fl_keep", m_data_s, 32'h11);

        // Upstream handshake during flush is dropped.
        s_valid_s = 1'b1;
        s_data_s  = 32'h77;
        flush_s   = 1'b1;
        tick();
        flush_s   = 1'b0;
        s_valid_s = 1'b0;
        chk_state("fl_drop", 1'b0, 1'b1, 2'd0);

        // Reset while ONE with an upstream word offered.
        m_ready_s = 1'b0;
        s_valid_s = 1'b1;
        s_data_s  = 32'h55;
        tick();
        chk_state("r_one", 1'b1, 1'b1, 2'd1);
        chk("r_one.data", m_data_s, 32'h55);
        rst_n_s  = 1'b0;
        s_data_s = 32'h66;
        tick();
        chk_state("r_mid", 1'b0, 1'b1, 2'd0);
        chk("r_mid.data", m_data_s, 32'h0);
        rst_n_s   = 1'b1;
        s_valid_s = 1'b0;
        m_ready_s = 1'b1;
        tick();
        chk_state("r_post", 1'b0, 1'b1, 2'd0);
        chk("r_post.data", m_data_s, 32'h0);

        // Random traffic against a queue model of the slice occupancy.
        sent_r = 0;
        recv_r = 0;
        cyc_r  = 0;
        while ((recv_r < int'(N_RAND)) && (cyc_r < 20000)) begin
            sv_s      = (sent_r < int'(N_RAND)) ? 1'($urandom_range(0, 1)) : 1'b0;
            mr_s      = 1'($urandom_range(0, 1));
            s_valid_s = sv_s;
            m_ready_s = mr_s;
            s_data_s  = $urandom;
            exp_v_s   = (q_s.size() > 0);
            exp_r_s   = (q_s.size() < 2);
            chk_state("rnd", exp_v_s, exp_r_s, 2'(q_s.size()));
            if (exp_v_s) begin
                chk("rnd.data", m_data_s, q_s[0]);
                if (mr_s) begin
                    void'(q_s.pop_front());
                    recv_r = recv_r + 1;
                end
            end
            if (sv_s && exp_r_s) begin
                q_s.push_back(s_data_s);
                sent_r = sent_r + 1;
            end
            tick();
            cyc_r = cyc_r + 1;
        end
        s_valid_s = 1'b0;
        chk("rnd.recv", 32'(recv_r), 32'(N_RAND));

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
